branch_resolve_unit: RTL and testbench

//   EX-stage consumer of the fetch-time branch predictor outputs. Carries each fetch's

---
 rtl/branch_resolve_unit_if.sv | 41 ++++
 rtl/branch_resolve_unit.sv | 146 ++++++++++++++
 tb/tb_branch_resolve_unit.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/branch_resolve_unit_if.sv
// Signal bundle between the fetch/EX pipeline and the branch resolve unit.
// The unit sits on the slave side; the pipeline (or a bench) drives the master side.
interface branch_resolve_unit_if #(
  parameter int PC_BITS  = 12,
  parameter int CNT_BITS = 16
);
  logic                F_stall;
  logic                MEM_stall;
  logic [PC_BITS-1:0]  F_pc;
  logic                F_BP_taken;
  logic [PC_BITS-1:0]  F_BP_target_pc;
  logic                EX_brn;
  logic [PC_BITS-1:0]  EX_pc;
  logic [PC_BITS-1:0]  EX_alu_out;
  logic                EX_true_taken;
  logic                redirect_valid;
  logic [PC_BITS-1:0]  redirect_pc;
  logic                flush;
  logic                upd_brn;
  logic [PC_BITS-1:0]  upd_pc;
  logic [PC_BITS-1:0]  upd_target;
  logic                upd_taken;
  logic [CNT_BITS-1:0] branch_cnt;
  logic [CNT_BITS-1:0] mispred_cnt;

  modport master (
    output F_stall, MEM_stall, F_pc, F_BP_taken, F_BP_target_pc,
    output EX_brn, EX_pc, EX_alu_out, EX_true_taken,
    input  redirect_valid, redirect_pc, flush,
    input  upd_brn, upd_pc, upd_target, upd_taken,
    input  branch_cnt, mispred_cnt
  );

  modport slave (
    input  F_stall, MEM_stall, F_pc, F_BP_taken, F_BP_target_pc,
    input  EX_brn, EX_pc, EX_alu_out, EX_true_taken,
    output redirect_valid, redirect_pc, flush,
    output upd_brn, upd_pc, upd_target, upd_taken,
    output branch_cnt, mispred_cnt
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: carries fetch-time predictions through D/EX shadow stages,
// detects mispredicts, drives redirect/flush, predictor update and saturating counters.
module branch_resolve_unit #(
  parameter int PC_BITS        = 12,
  parameter int RECOVER_CYCLES = 2,
  parameter int CNT_BITS       = 16
) (
  input logic                clk,
  input logic                rst,
  branch_resolve_unit_if.slave bus
);
  typedef enum logic [0:0] {IDLE = 1'b0, RECOVER = 1'b1} state_t;

  localparam logic [2:0]          RC_INIT = 3'(RECOVER_CYCLES - 1);
  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

  state_t              state_r, state_s;
  logic [2:0]          rc_r, rc_s;
  logic                d_v_r, d_taken_r, e_v_r, e_taken_r;
  logic [PC_BITS-1:0]  d_target_r, e_target_r;
  logic                adv_fd_s, adv_de_s, res_en_s, mispredict_s, upd_brn_s;
  logic [PC_BITS-1:0]  redirect_pc_s;
  logic [CNT_BITS-1:0] branch_cnt_r, mispred_cnt_r;

  function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_BITS'(1);
  endfunction

  assign adv_fd_s = ~bus.F_stall & ~bus.MEM_stall;
  assign adv_de_s = ~bus.MEM_stall;

  // Shadow stages D and E; a flush empties both and wins over any advance
  always_ff @(posedge clk) begin
    if (rst) begin
      d_v_r      <= 1'b0;
      d_taken_r  <= 1'b0;
      d_target_r <= '0;
      e_v_r      <= 1'b0;
      e_taken_r  <= 1'b0;
      e_target_r <= '0;
    end else if (mispredict_s) begin
      d_v_r <= 1'b0;
      e_v_r <= 1'b0;
    end else if (adv_fd_s) begin
      d_v_r      <= 1'b1;
      d_taken_r  <= bus.F_BP_taken;
      d_target_r <= bus.F_BP_target_pc;
      e_v_r      <= d_v_r;
      e_taken_r  <= d_taken_r;
      e_target_r <= d_target_r;
    end else if (adv_de_s) begin
      e_v_r <= 1'b0;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      rc_r    <= 3'd0;
    end else begin
      state_r <= state_s;
      rc_r    <= rc_s;
    end
  end

  // FSM next state: RECOVER drains wrong-path work, frozen while the back end stalls
  always_comb begin
    state_s = state_r;
    rc_s    = rc_r;
    case (state_r)
      IDLE: begin
        if (mispredict_s) begin
          state_s = RECOVER;
          rc_s    = RC_INIT;
        end else begin
          state_s = IDLE;
          rc_s    = rc_r;
        end
      end
      RECOVER: begin
        if (bus.MEM_stall) begin
          state_s = RECOVER;
          rc_s    = rc_r;
        end else if (rc_r == 3'd0) begin
          state_s = IDLE;
          rc_s    = 3'd0;
        end else begin
          state_s = RECOVER;
          rc_s    = rc_r - 3'd1;
        end
      end
      default: begin
        state_s = IDLE;
        rc_s    = 3'd0;
      end
    endcase
  end

  // FSM outputs: resolution enable, mispredict classification and redirect target
  always_comb begin
    res_en_s      = e_v_r & ~bus.MEM_stall & (state_r == IDLE);
    mispredict_s  = 1'b0;
    redirect_pc_s = '0;
    if (!res_en_s) begin
      mispredict_s = 1'b0;
    end else if (bus.EX_brn) begin
      mispredict_s = (e_taken_r != bus.EX_true_taken) |
                     (e_taken_r & bus.EX_true_taken & (e_target_r != bus.EX_alu_out));
    end else begin
      mispredict_s = e_taken_r;
    end
    if (bus.EX_brn && bus.EX_true_taken) begin
      redirect_pc_s = bus.EX_alu_out;
    end else begin
      redirect_pc_s = bus.EX_pc + PC_BITS'(1);
    end
    upd_brn_s = res_en_s & bus.EX_brn;
  end

  // Saturating performance counters
  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt_r  <= '0;
      mispred_cnt_r <= '0;
    end else begin
      if (upd_brn_s) begin
        branch_cnt_r <= sat_inc(branch_cnt_r);
      end
      if (mispredict_s) begin
        mispred_cnt_r <= sat_inc(mispred_cnt_r);
      end
    end
  end

  // Data outputs are zeroed while their strobe is low so idle/reset outputs read 0
  assign bus.redirect_valid = mispredict_s;
  assign bus.flush          = mispredict_s;
  assign bus.redirect_pc    = mispredict_s ? redirect_pc_s : '0;
  assign bus.upd_brn        = upd_brn_s;
  assign bus.upd_pc         = upd_brn_s ? bus.EX_pc : '0;
  assign bus.upd_target     = upd_brn_s ? bus.EX_alu_out : '0;
  assign bus.upd_taken      = upd_brn_s & bus.EX_true_taken;
  assign bus.branch_cnt     = branch_cnt_r;
  assign bus.mispred_cnt    = mispred_cnt_r;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: two instances (default, and long-recover/narrow-counter)
// share stimulus and are compared every cycle against an in-bench behavioural model.
module tb_branch_resolve_unit;
  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  branch_resolve_unit_if #(.PC_BITS(12), .CNT_BITS(16)) bus0();
  branch_resolve_unit_if #(.PC_BITS(12), .CNT_BITS(4))  bus1();

  branch_resolve_unit #(.PC_BITS(12), .RECOVER_CYCLES(2), .CNT_BITS(16)) dut (
    .clk(clk), .rst(rst), .bus(bus0));
  branch_resolve_unit #(.PC_BITS(12), .RECOVER_CYCLES(4), .CNT_BITS(4)) dut_long (
    .clk(clk), .rst(rst), .bus(bus1));

  // Model state: predictions sitting in D and E, remaining recovery cycles, counter values
  bit         m_dv[2], m_dtk[2], m_ev[2], m_etk[2];
  logic [11:0] m_dtg[2], m_etg[2];
  int         m_rec[2], m_bc[2], m_mc[2];
  bit         x_mis[2], x_ub[2];

  function automatic int rec_len(input int k);
    return (k == 0) ? 2 : 4;
  endfunction

  function automatic int cnt_max(input int k);
    return (k == 0) ? 65535 : 15;
  endfunction

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[dut%0d] @%0t: got %0h expected %0h", name, k, $time, act, exp);
    end
  endtask

  task automatic cmp_dut(input int k, input logic rv, input logic fl, input logic [11:0] rpc,
                         input logic ub, input logic [11:0] upc, input logic [11:0] utg,
                         input logic utk, input logic [15:0] bc, input logic [15:0] mc);
    bit res, mis;
    logic [11:0] tgt;
    res = m_ev[k] && !bus0.MEM_stall && (m_rec[k] == 0);
    if (!res) mis = 1'b0;
    else if (bus0.EX_brn)
      mis = (m_etk[k] != bus0.EX_true_taken) ||
            (m_etk[k] && bus0.EX_true_taken && (m_etg[k] != bus0.EX_alu_out));
    else mis = m_etk[k];
    tgt = (bus0.EX_brn && bus0.EX_true_taken) ? bus0.EX_alu_out
                                              : 12'((int'(bus0.EX_pc) + 1) % 4096);
    x_mis[k] = mis;
    x_ub[k]  = res && bus0.EX_brn;
    chk("redirect_valid", k, 32'(rv), 32'(mis));
    chk("flush", k, 32'(fl), 32'(mis));
    if (mis) chk("redirect_pc", k, 32'(rpc), 32'(tgt));
    chk("upd_brn", k, 32'(ub), 32'(x_ub[k]));
    if (x_ub[k]) begin
      chk("upd_pc", k, 32'(upc), 32'(bus0.EX_pc));
      chk("upd_target", k, 32'(utg), 32'(bus0.EX_alu_out));
      chk("upd_taken", k, 32'(utk), 32'(bus0.EX_true_taken));
    end
    chk("branch_cnt", k, 32'(bc), 32'(m_bc[k]));
    chk("mispred_cnt", k, 32'(mc), 32'(m_mc[k]));
  endtask

  task automatic model_step(input int k);
    if (rst) begin
      m_dv[k] = 0; m_dtk[k] = 0; m_dtg[k] = '0;
      m_ev[k] = 0; m_etk[k] = 0; m_etg[k] = '0;
      m_rec[k] = 0; m_bc[k] = 0; m_mc[k] = 0;
    end else begin
      if (x_ub[k] && m_bc[k] < cnt_max(k)) m_bc[k]++;
      if (x_mis[k] && m_mc[k] < cnt_max(k)) m_mc[k]++;
      if (x_mis[k]) m_rec[k] = rec_len(k);
      else if (m_rec[k] > 0 && !bus0.MEM_stall) m_rec[k]--;
      if (x_mis[k]) begin
        m_dv[k] = 0; m_ev[k] = 0;
      end else if (!bus0.MEM_stall) begin
        if (bus0.F_stall) m_ev[k] = 0;
        else begin
          m_ev[k] = m_dv[k]; m_etk[k] = m_dtk[k]; m_etg[k] = m_dtg[k];
          m_dv[k] = 1; m_dtk[k] = bus0.F_BP_taken; m_dtg[k] = bus0.F_BP_target_pc;
        end
      end
    end
  endtask

  // Compare process: check mid-cycle against the model, then advance the model at the edge
  always begin
    @(negedge clk);
    #3;
    cmp_dut(0, bus0.redirect_valid, bus0.flush, bus0.redirect_pc, bus0.upd_brn, bus0.upd_pc,
            bus0.upd_target, bus0.upd_taken, bus0.branch_cnt, bus0.mispred_cnt);
    cmp_dut(1, bus1.redirect_valid, bus1.flush, bus1.redirect_pc, bus1.upd_brn, bus1.upd_pc,
            bus1.upd_target, bus1.upd_taken, 16'(bus1.branch_cnt), 16'(bus1.mispred_cnt));
    @(posedge clk);
    model_step(0);
    model_step(1);
  end

  task automatic set_in(input logic r, input logic fs, input logic ms, input logic [11:0] fpc,
                        input logic ftk, input logic [11:0] ftg, input logic brn,
                        input logic [11:0] epc, input logic [11:0] alu, input logic tt);
    rst = r;
    bus0.F_stall = fs; bus0.MEM_stall = ms; bus0.F_pc = fpc; bus0.F_BP_taken = ftk;
    bus0.F_BP_target_pc = ftg; bus0.EX_brn = brn; bus0.EX_pc = epc;
    bus0.EX_alu_out = alu; bus0.EX_true_taken = tt;
    bus1.F_stall = fs; bus1.MEM_stall = ms; bus1.F_pc = fpc; bus1.F_BP_taken = ftk;
    bus1.F_BP_target_pc = ftg; bus1.EX_brn = brn; bus1.EX_pc = epc;
    bus1.EX_alu_out = alu; bus1.EX_true_taken = tt;
  endtask

  // One cycle: drive at the falling edge, return after the compare process has sampled
  task automatic cyc(input logic r, input logic fs, input logic ms, input logic [11:0] fpc,
                     input logic ftk, input logic [11:0] ftg, input logic brn,
                     input logic [11:0] epc, input logic [11:0] alu, input logic tt);
    @(negedge clk);
    set_in(r, fs, ms, fpc, ftk, ftg, brn, epc, alu, tt);
    #4;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      cyc(1'b0, 1'b0, 1'b0, 12'(16'h500 + i), 1'b0, 12'h000, 1'b0, 12'h000, 12'h000, 1'b0);
  endtask

  initial begin
    set_in(1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 12'h000, 12'h000, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 12'h000, 12'h000, 1'b0);
    chk("reset_redirect", 0, 32'(bus0.redirect_valid), 32'h0);
    chk("reset_upd_brn", 0, 32'(bus0.upd_brn), 32'h0);
    chk("reset_branch_cnt", 0, 32'(bus0.branch_cnt), 32'h0);

    // Correctly predicted taken branch at 0x010 -> 0x040
    cyc(1'b0, 1'b0, 1'b0, 12'h010, 1'b1, 12'h040, 1'b0, 12'h000, 12'h000, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 12'h011, 1'b0, 12'h000, 1'b0, 12'h000, 12'h000, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 12'h012, 1'b0, 12'h000, 1'b1, 12'h010, 12'h040, 1'b1);
    chk("t1_redirect", 0, 32'(bus0.redirect_valid), 32'h0);
    chk("t1_upd_brn", 0, 32'(bus0.upd_brn), 32'h1);
    chk("t1_upd_target", 0, 32'(bus0.upd_target), 32'h040);
    cyc(1'b0, 1'b0, 1'b0, 12'h020, 1'b0, 12'h000, 1'b0, 12'h011, 12'h000, 1'b0);
    chk("t1_branch_cnt", 0, 32'(bus0.branch_cnt), 32'h1);
    chk("t1_mispred_cnt", 0, 32'(bus0.mispred_cnt), 32'h0);

    // Not-taken prediction for 0x020 resolves taken to 0x080
    cyc(1'b0, 1'b0, 1'b0, 12'h021, 1'b0, 12'h000, 1'b0, 12'h012, 12'h000, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 12'hFFF, 1'b1, 12'h100, 1'b1, 12'h020, 12'h080, 1'b1);
    chk("t2_redirect", 0, 32'(bus0.redirect_valid), 32'h1);
    chk("t2_flush", 0, 32'(bus0.flush), 32'h1);
    chk("t2_redirect_pc", 0, 32'(bus0.redirect_pc), 32'h080);
    chk("t2_redirect_long", 1, 32'(bus1.redirect_valid), 32'h1);
    cyc(1'b0, 1'b0, 1'b0, 12'hFFF, 1'b1, 12'h100, 1'b1, 12'h020, 12'h080, 1'b1);
    chk("t2_single_pulse", 0, 32'(bus0.redirect_valid), 32'h0);
    chk("t2_mispred_cnt", 0, 32'(bus0.mispred_cnt), 32'h1);
    chk("t2_branch_cnt", 0, 32'(bus0.branch_cnt), 32'h2);
    cyc(1'b0, 1'b0, 1'b0, 12'h080, 1'b0, 12'h000, 1'b0, 12'h000, 12'h000, 1'b0);

    // 0xFFF predicted taken resolves not-taken: wrap to 0x000; dut_long still recovering
    cyc(1'b0, 1'b0, 1'b0, 12'h081, 1'b0, 12'h000, 1'b1, 12'hFFF, 12'h555, 1'b0);
    chk("t3_redirect", 0, 32'(bus0.redirect_valid), 32'h1);
    chk("t3_wrap_pc", 0, 32'(bus0.redirect_pc), 32'h000);
    chk("t5_ignored_redirect", 1, 32'(bus1.redirect_valid), 32'h0);
    chk("t5_ignored_upd", 1, 32'(bus1.upd_brn), 32'h0);
    idle(1);
    chk("t3_mispred_cnt", 0, 32'(bus0.mispred_cnt), 32'h2);
    chk("t5_mispred_cnt", 1, 32'(bus1.mispred_cnt), 32'h1);
    idle(5);

    // Back-end stall with a branch sitting in EX
    cyc(1'b0, 1'b0, 1'b0, 12'h200, 1'b1, 12'h300, 1'b0, 12'h000, 12'h000, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 12'h201, 1'b0, 12'h000, 1'b0, 12'h000, 12'h000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 12'h202, 1'b0, 12'h000, 1'b1, 12'h200, 12'h300, 1'b1);
      chk("t4_stall_upd", 0, 32'(bus0.upd_brn), 32'h0);
      chk("t4_stall_redirect", 0, 32'(bus0.redirect_valid), 32'h0);
    end
    cyc(1'b0, 1'b0, 1'b0, 12'h202, 1'b0, 12'h000, 1'b1, 12'h200, 12'h300, 1'b1);
    chk("t4_release_upd", 0, 32'(bus0.upd_brn), 32'h1);
    idle(1);
    chk("t4_branch_cnt", 0, 32'(bus0.branch_cnt), 32'h4);

    // Randomized traffic, EX outcome biased toward the prediction held in dut's E stage
    for (int i = 0; i < 800; i++) begin
      bit good;
      logic [11:0] epc;
      @(posedge clk);
      #1;
      good = 1'($urandom_range(0, 1));
      epc  = ($urandom_range(0, 7) == 0) ? 12'hFFF : 12'($urandom);
      cyc(1'b0, ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0), 12'($urandom),
          1'($urandom), 12'($urandom), ($urandom_range(0, 2) != 0), epc,
          good ? m_etg[0] : 12'($urandom), good ? m_etk[0] : 1'($urandom));
    end
    idle(10);
    chk("sat_branch_cnt", 1, 32'(bus1.branch_cnt), 32'hF);
    chk("sat_mispred_cnt", 1, 32'(bus1.mispred_cnt), 32'hF);

    // Stale taken prediction on a non-branch, then reset in the middle of RECOVER
    cyc(1'b0, 1'b0, 1'b0, 12'h300, 1'b1, 12'h310, 1'b0, 12'h000, 12'h000, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 12'h301, 1'b0, 12'h000, 1'b0, 12'h000, 12'h000, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 12'h302, 1'b0, 12'h000, 1'b0, 12'h300, 12'h000, 1'b0);
    chk("stale_redirect", 0, 32'(bus0.redirect_valid), 32'h1);
    chk("stale_pc", 0, 32'(bus0.redirect_pc), 32'h301);
    cyc(1'b1, 1'b0, 1'b0, 12'h303, 1'b0, 12'h000, 1'b0, 12'h000, 12'h000, 1'b0);
    chk("t6_pre_reset_sat", 1, 32'(bus1.mispred_cnt), 32'hF);
    cyc(1'b0, 1'b0, 1'b0, 12'h400, 1'b1, 12'h410, 1'b0, 12'h000, 12'h000, 1'b0);
    chk("t6_redirect", 1, 32'(bus1.redirect_valid), 32'h0);
    chk("t6_upd_brn", 1, 32'(bus1.upd_brn), 32'h0);
    chk("t6_branch_cnt", 1, 32'(bus1.branch_cnt), 32'h0);
    chk("t6_mispred_cnt", 1, 32'(bus1.mispred_cnt), 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 12'h401, 1'b0, 12'h000, 1'b0, 12'h000, 12'h000, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 12'h402, 1'b0, 12'h000, 1'b1, 12'h400, 12'h410, 1'b0);
    chk("t6_idle_after_reset", 1, 32'(bus1.redirect_valid), 32'h1);
    chk("t6_idle_pc", 1, 32'(bus1.redirect_pc), 32'h401);
    idle(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
